// File: rtl/encoder32x5_rr.sv
// -----------------------------------------------------------------------------
// encoder32x5_rr
//
// Purpose
//   Collects 32 request lines into a pending register and hands them out one
//   at a time as a 5-bit binary index (plus its one-hot echo) over a
//   valid/ready handshake. A request is cleared once the consumer accepts it.
//   Priority is either fixed (index 0 highest) or round-robin, where the scan
//   starts one past the most recently accepted index.
//
// Parameters
//   N            number of request lines (32 for this block)
//   W            index width, log2(N)
//   ROUND_ROBIN  1: rotating priority, 0: fixed priority with index 0 highest
//
// Ports
//   clk         in   1    rising-edge clock
//   rst         in   1    synchronous, active-high reset
//   set_vec     in   N    request pulses; each 1 bit sets its pending bit
//   flush       in   1    drop all pending bits (same-cycle set_vec kept)
//   out_ready   in   1    consumer accepts out_idx this cycle
//   out_valid   out  1    at least one pending bit is set
//   out_idx     out  W    index of the selected pending bit (0 when idle)
//   out_onehot  out  N    one-hot of out_idx, all zeros when idle
//   pending     out  N    pending register
//   pend_count  out  W+1  population count of pending
// -----------------------------------------------------------------------------
module encoder32x5_rr #(
  parameter int N           = 32,
  parameter int W           = 5,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] set_vec,
  input  logic         flush,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending,
  output logic [W:0]   pend_count
);

  // Round-robin pointer: the index scanned first on the next selection.
  logic [W-1:0] ptr;

  // Scan origin. In fixed-priority mode the scan always starts at index 0,
  // so the pointer register has no effect on selection.
  logic [W-1:0] scan_base;

  // pending rotated so that bit 0 corresponds to index scan_base.
  logic [N-1:0] rotated;

  logic         rot_found;
  logic [W-1:0] rot_idx;
  logic         accept;
  logic [N-1:0] clr_vec;

  assign scan_base = ROUND_ROBIN ? ptr : '0;

  // Rotate pending right by scan_base. The W-bit index sum wraps modulo N,
  // which turns the circular scan into a plain lowest-bit-first search.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    rotated = '0;
    for (int i = 0; i < N; i++) begin
      rotated[i] = pending[W'(i) + scan_base];
    end
  end

  // Lowest set bit of the rotated vector. Scanning downward lets the last
  // match (the lowest index) win.
  always_comb begin
    rot_found = 1'b0;
    rot_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        rot_found = 1'b1;
        rot_idx   = W'(i);
      end
    end
  end

  // Undo the rotation; the add wraps in W bits, matching the circular scan.
  assign out_valid  = rot_found;
  assign out_idx    = rot_found ? (rot_idx + scan_base) : '0;
  assign out_onehot = rot_found ? (N'(1) << out_idx) : '0;

  assign accept  = out_valid & out_ready;
  assign clr_vec = accept ? out_onehot : '0;

  always_comb begin
    pend_count = '0;
    for (int i = 0; i < N; i++) begin
      pend_count = pend_count + {{W{1'b0}}, pending[i]};
    end
  end

  // rst outranks flush; flush keeps same-cycle requests and discards any
  // accept, so the pointer only moves on an accept in a normal cycle.
  // Clearing before OR-ing set_vec makes a new request win over the clear of
  // the same bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      pending <= '0;
      ptr     <= '0;
    end else if (flush) begin
      pending <= set_vec;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (accept) begin
        ptr <= out_idx + W'(1);
      end
    end
  end

endmodule
